therm_scan_converter: RTL

//   Multi-channel successor to the single-thermistor voltage-to-temperature converter.

---
 rtl/therm_scan_if.sv | 28 ++
 rtl/therm_scan_converter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/therm_scan_if.sv
// Sample/result bundle between the ADC sequencer and the multi-channel
// thermistor converter.
interface therm_scan_if #(
    parameter int N_CH = 4,
    parameter int V_W  = 12,
    parameter int T_W  = 11,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic            v_valid;
    logic            v_ready;
    logic [CH_W-1:0] v_ch;
    logic [V_W-1:0]  v_therm;
    logic            temp_valid;
    logic [CH_W-1:0] temp_ch;
    logic [T_W-1:0]  temp_therm;
    logic [N_CH-1:0] alarm;
    logic            err_ch;

    modport master (
        output v_valid, v_ch, v_therm,
        input  v_ready, temp_valid, temp_ch, temp_therm, alarm, err_ch
    );

    modport slave (
        input  v_valid, v_ch, v_therm,
        output v_ready, temp_valid, temp_ch, temp_therm, alarm, err_ch
    );
endinterface

// File: rtl/therm_scan_converter.sv
// Per-channel sample averaging, linear voltage-to-temperature conversion and
// per-channel over-temperature alarm with hysteresis.
module therm_scan_converter #(
    parameter int N_CH       = 4,
    parameter int V_W        = 12,
    parameter int T_W        = 11,
    parameter int AVG_LOG2   = 2,
    parameter int SLOPE      = 64,
    parameter int OFFSET     = 1100,
    parameter int ALARM_HI   = 700,
    parameter int ALARM_HYST = 50
) (
    input  logic         clk,
    input  logic         rst_n,
    therm_scan_if.slave  bus
);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ACC_W    = V_W + AVG_LOG2;
    localparam int CNT_W    = AVG_LOG2 + 1;
    localparam int N_AVG    = 1 << AVG_LOG2;
    localparam int P_W      = V_W + 8;
    localparam int T_MAX    = (1 << T_W) - 1;
    localparam int ALARM_LO = ALARM_HI - ALARM_HYST;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t            state_reg, state_next;
    logic              ready_en_reg;
    logic [ACC_W-1:0]  acc_reg [N_CH];
    logic [CNT_W-1:0]  cnt_reg [N_CH];
    logic [V_W-1:0]    avg_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [P_W-1:0]    prod_reg;
    logic              temp_valid_reg;
    logic [CH_W-1:0]   temp_ch_reg;
    logic [T_W-1:0]    temp_therm_reg;
    logic [N_CH-1:0]   alarm_reg, alarm_next;
    logic              err_reg;

    logic              ready;
    logic              fire;
    logic              ch_legal;
    logic              complete;
    logic [N_CH-1:0]   hit;
    logic [N_CH-1:0]   done;
    logic [ACC_W-1:0]  sum_sel;
    int                t_raw;
    logic [T_W-1:0]    temp_calc;

    assign fire     = bus.v_valid && ready;
    assign ch_legal = int'(bus.v_ch) < N_CH;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign hit[gi]  = fire && ch_legal && (bus.v_ch == CH_W'(gi));
            assign done[gi] = hit[gi] && (cnt_reg[gi] == CNT_W'(N_AVG - 1));

            // Alarm only moves when this channel's result is being emitted.
            always_comb begin
                alarm_next[gi] = alarm_reg[gi];
                if (state_reg == OUT && ch_reg == CH_W'(gi)) begin
                    if (int'(temp_calc) >= ALARM_HI)
                        alarm_next[gi] = 1'b1;
                    else if (int'(temp_calc) < ALARM_LO)
                        alarm_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign complete = |done;

    always_comb begin
        sum_sel = '0;
        for (int i = 0; i < N_CH; i++)
            if (done[i]) sum_sel = acc_reg[i] + ACC_W'(bus.v_therm);
    end

    // Signed difference, then saturate into the unsigned output range.
    always_comb begin
        t_raw = OFFSET - int'(prod_reg >> 8);
        if (t_raw < 0)
            temp_calc = '0;
        else if (t_raw > T_MAX)
            temp_calc = T_W'(T_MAX);
        else
            temp_calc = T_W'(t_raw);
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = ready_en_reg;
                if (complete) state_next = MUL;
            end
            MUL:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_reg   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                acc_reg[i] <= '0;
                cnt_reg[i] <= '0;
            end
            avg_reg        <= '0;
            ch_reg         <= '0;
            prod_reg       <= '0;
            temp_valid_reg <= 1'b0;
            temp_ch_reg    <= '0;
            temp_therm_reg <= '0;
            alarm_reg      <= '0;
            err_reg        <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                if (done[i]) begin
                    acc_reg[i] <= '0;
                    cnt_reg[i] <= '0;
                end else if (hit[i]) begin
                    acc_reg[i] <= acc_reg[i] + ACC_W'(bus.v_therm);
                    cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
                end
            end
            if (complete) begin
                avg_reg <= V_W'(sum_sel >> AVG_LOG2);
                ch_reg  <= bus.v_ch;
            end
            if (fire && !ch_legal) err_reg <= 1'b1;
            if (state_reg == MUL) prod_reg <= P_W'(avg_reg) * P_W'(SLOPE);
            temp_valid_reg <= (state_reg == OUT);
            if (state_reg == OUT) begin
                temp_therm_reg <= temp_calc;
                temp_ch_reg    <= ch_reg;
            end
            alarm_reg <= alarm_next;
        end
    end

    assign bus.v_ready    = ready;
    assign bus.temp_valid = temp_valid_reg;
    assign bus.temp_ch    = temp_ch_reg;
    assign bus.temp_therm = temp_therm_reg;
    assign bus.alarm      = alarm_reg;
    assign bus.err_ch     = err_reg;
endmodule
